// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared states, header codes and frame length for the DHT11 response framer
// DHT11_FRAME_CHECKSUM_EN adds a fourth XOR checksum byte to every frame.
package dht11_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [7:0] HDR_TEMP   = 8'h01;
   localparam logic [7:0] HDR_HUM    = 8'h02;
   localparam logic [7:0] HDR_ERR    = 8'hEE;
   localparam logic [7:0] HDR_BADREQ = 8'hEF;

   localparam logic [1:0] REQ_TEMP = 2'b01;
   localparam logic [1:0] REQ_HUM  = 2'b10;

`ifdef DHT11_FRAME_CHECKSUM_EN
   localparam int FRAME_LEN = 4;
`else
   localparam int FRAME_LEN = 3;
`endif

   localparam int IDX_W = 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

endpackage

// File: rtl/dht11_frame_builder.sv
// rtl/dht11_frame_builder.sv - combinational frame byte selection from measurement fields
// With DHT11_FRAME_CHECKSUM_EN, byte 3 is the XOR of bytes 0..2.
module dht11_frame_builder
   import dht11_pkg::*;
(
   input  logic [1:0]       req,
   input  logic [15:0]      result,
   input  logic             err,
   input  logic [IDX_W-1:0] idx,
   output logic [7:0]       data
);

   logic [7:0] hdr;
   logic [7:0] b1;
   logic [7:0] b2;

   // Error flag wins over the request code; bad codes carry no payload.
   always_comb begin
      hdr = HDR_BADREQ;
      b1  = 8'h00;
      b2  = 8'h00;
      if (err) begin
         hdr = HDR_ERR;
      end else if (req == REQ_TEMP) begin
         hdr = HDR_TEMP;
         b1  = result[15:8];
         b2  = result[7:0];
      end else if (req == REQ_HUM) begin
         hdr = HDR_HUM;
         b1  = result[15:8];
         b2  = result[7:0];
      end
   end

   always_comb begin
      data = 8'h00;
      case (idx)
         2'd0:    data = hdr;
         2'd1:    data = b1;
         2'd2:    data = b2;
`ifdef DHT11_FRAME_CHECKSUM_EN
         2'd3:    data = hdr ^ b1 ^ b2;
`endif
         default: data = 8'h00;
      endcase
   end

endmodule

// File: rtl/dht11_response_framer.sv
// rtl/dht11_response_framer.sv - captures one DHT11 measurement and streams it as a byte frame to the UART
// DHT11_FRAME_CHECKSUM_EN selects the 4-byte frame with trailing checksum.
module dht11_response_framer
   import dht11_pkg::*;
#(
   parameter int GAP_CYCLES = 0,
   parameter int GAP_W      = 16
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [1:0]  rsp_req,
   input  logic [15:0] rsp_result,
   input  logic        rsp_err,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [GAP_W-1:0] gap_cnt, gap_n;
   logic [1:0]       cap_req;
   logic [15:0]      cap_result;
   logic             cap_err;
   logic [7:0]       tx_data_q;
   logic [7:0]       byte_next;
   logic             frame_done_q, done_n;
   logic             load, capture, last;

   logic [1:0]       sel_req;
   logic [15:0]      sel_result;
   logic             sel_err;

   // The first byte is built from the live inputs so it is ready the cycle after the handshake.
   assign sel_req    = (state == IDLE) ? rsp_req    : cap_req;
   assign sel_result = (state == IDLE) ? rsp_result : cap_result;
   assign sel_err    = (state == IDLE) ? rsp_err    : cap_err;

   dht11_frame_builder u_builder (
      .req    (sel_req),
      .result (sel_result),
      .err    (sel_err),
      .idx    (idx_n),
      .data   (byte_next)
   );

   assign last = (idx == LAST_IDX);

   always_comb begin
      state_n = state;
      idx_n   = idx;
      gap_n   = gap_cnt;
      done_n  = 1'b0;
      load    = 1'b0;
      capture = 1'b0;
      case (state)
         IDLE: begin
            if (rsp_valid) begin
               capture = 1'b1;
               load    = 1'b1;
               idx_n   = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               if (GAP_CYCLES > 0) begin
                  state_n = GAP;
                  gap_n   = GAP_LOAD;
               end else if (last) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  idx_n = idx + 1'b1;
                  load  = 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               if (last) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  idx_n   = idx + 1'b1;
                  load    = 1'b1;
                  state_n = SEND;
               end
            end else begin
               gap_n = gap_cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         gap_cnt      <= '0;
         cap_req      <= '0;
         cap_result   <= '0;
         cap_err      <= 1'b0;
         tx_data_q    <= 8'h00;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         gap_cnt      <= gap_n;
         frame_done_q <= done_n;
         if (capture) begin
            cap_req    <= rsp_req;
            cap_result <= rsp_result;
            cap_err    <= rsp_err;
         end
         if (load) begin
            tx_data_q <= byte_next;
         end
      end
   end

   assign rsp_ready  = (state == IDLE);
   assign tx_valid   = (state == SEND);
   assign busy       = (state != IDLE);
   assign tx_data    = tx_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dht11_response_framer.sv
// tb/tb_dht11_response_framer.sv - scoreboard bench for dht11_response_framer (GAP 0 and GAP 3 instances)
module tb_dht11_response_framer;

`ifdef DHT11_FRAME_CHECKSUM_EN
   localparam int FLEN = 4;
`else
   localparam int FLEN = 3;
`endif
   localparam int GAPN = 3;

   logic        clock;
   logic        rst_n;

   logic        rsp_valid, rsp_ready, rsp_err, tx_valid, tx_ready, busy, frame_done;
   logic [1:0]  rsp_req;
   logic [15:0] rsp_result;
   logic [7:0]  tx_data;

   logic        g_rsp_valid, g_rsp_ready, g_rsp_err, g_tx_valid, g_tx_ready, g_busy, g_frame_done;
   logic [1:0]  g_rsp_req;
   logic [15:0] g_rsp_result;
   logic [7:0]  g_tx_data;

   logic [7:0]  exp_q[$];
   logic [7:0]  g_exp_q[$];
   int          errors = 0;
   int          checks = 0;

   dht11_response_framer #(.GAP_CYCLES(0), .GAP_W(16)) dut (
      .clock(clock), .rst_n(rst_n),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_req(rsp_req),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .busy(busy), .frame_done(frame_done)
   );

   dht11_response_framer #(.GAP_CYCLES(GAPN), .GAP_W(16)) dut_gap (
      .clock(clock), .rst_n(rst_n),
      .rsp_valid(g_rsp_valid), .rsp_ready(g_rsp_ready), .rsp_req(g_rsp_req),
      .rsp_result(g_rsp_result), .rsp_err(g_rsp_err),
      .tx_valid(g_tx_valid), .tx_ready(g_tx_ready), .tx_data(g_tx_data),
      .busy(g_busy), .frame_done(g_frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic push_expected(input bit to_gap, input logic [1:0] req,
                                input logic [15:0] res, input logic err);
      logic [7:0] f[4];
      f[1] = 8'h00;
      f[2] = 8'h00;
      if (err)               f[0] = 8'hEE;
      else if (req == 2'b01) begin f[0] = 8'h01; f[1] = res[15:8]; f[2] = res[7:0]; end
      else if (req == 2'b10) begin f[0] = 8'h02; f[1] = res[15:8]; f[2] = res[7:0]; end
      else                   f[0] = 8'hEF;
      f[3] = f[0] ^ f[1] ^ f[2];
      for (int i = 0; i < FLEN; i++) begin
         if (to_gap) g_exp_q.push_back(f[i]);
         else        exp_q.push_back(f[i]);
      end
   endtask

   task automatic send_rsp(input logic [1:0] req, input logic [15:0] res, input logic err);
      int n = 0;
      while (!rsp_ready && n < 50) begin
         @(posedge clock); #1; n++;
      end
      checks++;
      if (rsp_ready !== 1'b1) begin
         errors++; $display("FAIL send_wait_ready: rsp_ready=%b expected 1", rsp_ready);
      end
      rsp_valid = 1'b1; rsp_req = req; rsp_result = res; rsp_err = err;
      push_expected(1'b0, req, res, err);
      @(posedge clock); #1;
      rsp_valid = 1'b0;
   endtask

   task automatic collect(input int stall, input int len_exp);
      int         n = 1;
      int         st = 0;
      bit         done = 0;
      logic [7:0] held = 8'h00;
      logic [7:0] e;
      while (!done) begin
         if (frame_done === 1'b1) begin
            checks++;
            if (n != len_exp) begin
               errors++; $display("FAIL frame_len: got %0d cycles expected %0d", n, len_exp);
            end
            checks++;
            if (exp_q.size() != 0) begin
               errors++; $display("FAIL frame_bytes_left: got %0d expected 0", exp_q.size());
            end
            done = 1;
         end else if (n > 200) begin
            checks++; errors++;
            $display("FAIL frame_timeout: got no frame_done after %0d cycles expected <= 200", n);
            done = 1;
         end else if (tx_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL tx_valid_drop: got tx_valid=%b expected 1 at cycle %0d", tx_valid, n);
         end else begin
            if (st == 0) held = tx_data;
            else begin
               checks++;
               if (tx_data !== held) begin
                  errors++; $display("FAIL stall_stable: got %h expected %h", tx_data, held);
               end
            end
            checks++;
            if (rsp_ready !== 1'b0 || busy !== 1'b1) begin
               errors++; $display("FAIL busy_flags: got rsp_ready=%b busy=%b expected 0 1", rsp_ready, busy);
            end
            if (st < stall) begin
               tx_ready = 1'b0; st++;
            end else begin
               tx_ready = 1'b1; st = 0;
               e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
               checks++;
               if (tx_data !== e) begin
                  errors++; $display("FAIL frame_byte: got %h expected %h", tx_data, e);
               end
            end
         end
         if (!done) begin
            @(posedge clock); #1; n++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b data=%h busy=%b done=%b expected 0 00 0 0",
                  tx_valid, tx_data, busy, frame_done);
      end
      rst_n = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (rsp_ready !== 1'b1 || g_rsp_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b/%b expected 1/1", rsp_ready, g_rsp_ready);
      end
   endtask

   task automatic test_temp_frame();
      send_rsp(2'b01, 16'h1A05, 1'b0);
      collect(0, FLEN + 1);
   endtask

   task automatic test_err_frame();
      send_rsp(2'b10, 16'h3700, 1'b1);
      collect(0, FLEN + 1);
   endtask

   task automatic test_stall();
      tx_ready = 1'b0;
      send_rsp(2'b10, 16'h4102, 1'b0);
      collect(5, FLEN * 6 + 1);
   endtask

   task automatic test_gap();
      int n = 1;
      int gap = 0;
      bit seen = 0;
      bit done = 0;
      logic [7:0] e;
      g_tx_ready = 1'b1;
      g_rsp_valid = 1'b1; g_rsp_req = 2'b01; g_rsp_result = 16'h1905; g_rsp_err = 1'b0;
      push_expected(1'b1, 2'b01, 16'h1905, 1'b0);
      @(posedge clock); #1;
      g_rsp_valid = 1'b0;
      while (!done) begin
         if (g_frame_done === 1'b1) begin
            checks++;
            if (gap != GAPN) begin
               errors++; $display("FAIL gap_final: got %0d idle cycles expected %0d", gap, GAPN);
            end
            checks++;
            if (n != FLEN * (GAPN + 1) + 1 || g_exp_q.size() != 0) begin
               errors++; $display("FAIL gap_frame_len: got %0d cycles, %0d left expected %0d, 0",
                                  n, g_exp_q.size(), FLEN * (GAPN + 1) + 1);
            end
            done = 1;
         end else if (n > 200) begin
            checks++; errors++;
            $display("FAIL gap_timeout: got no frame_done after %0d cycles expected <= 200", n);
            done = 1;
         end else if (g_tx_valid === 1'b1) begin
            if (seen) begin
               checks++;
               if (gap != GAPN) begin
                  errors++; $display("FAIL gap_len: got %0d idle cycles expected %0d", gap, GAPN);
               end
            end
            e = (g_exp_q.size() != 0) ? g_exp_q.pop_front() : 8'hXX;
            checks++;
            if (g_tx_data !== e) begin
               errors++; $display("FAIL gap_byte: got %h expected %h", g_tx_data, e);
            end
            seen = 1; gap = 0;
         end else begin
            gap++;
         end
         if (!done) begin
            @(posedge clock); #1; n++;
         end
      end
      g_tx_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      tx_ready = 1'b1;
      send_rsp(2'b01, 16'h1A05, 1'b0);
      rsp_valid = 1'b1; rsp_req = 2'b11; rsp_result = 16'h7788; rsp_err = 1'b0;
      collect(0, FLEN + 1);
      checks++;
      if (rsp_ready !== 1'b1) begin
         errors++; $display("FAIL done_cycle_ready: got %b expected 1", rsp_ready);
      end
      push_expected(1'b0, 2'b11, 16'h7788, 1'b0);
      @(posedge clock); #1;
      rsp_valid = 1'b0;
      collect(0, FLEN + 1);
   endtask

   task automatic test_reset_mid();
      tx_ready = 1'b1;
      send_rsp(2'b01, 16'h1905, 1'b0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
         errors++; $display("FAIL async_reset: got valid=%b busy=%b data=%h expected 0 0 00",
                            tx_valid, busy, tx_data);
      end
      @(posedge clock); #1;
      rst_n = 1'b1;
      tx_ready = 1'b0;
      exp_q.delete();
      @(posedge clock); #1;
      checks++;
      if (rsp_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_ready: got %b expected 1", rsp_ready);
      end
      send_rsp(2'b10, 16'h4102, 1'b0);
      collect(0, FLEN + 1);
   endtask

   initial begin
      rst_n = 1'b0;
      rsp_valid = 1'b0; rsp_req = 2'b00; rsp_result = 16'h0000; rsp_err = 1'b0; tx_ready = 1'b0;
      g_rsp_valid = 1'b0; g_rsp_req = 2'b00; g_rsp_result = 16'h0000; g_rsp_err = 1'b0; g_tx_ready = 1'b0;
      test_reset();
      test_temp_frame();
      test_err_frame();
      test_stall();
      test_gap();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
